if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised IF/ID decoupling queue between the fetch stage and the decode stage. It generalises the single IF/ID pipeline register into a DEPTH-entry first-in/first-out buffer of {PC, instruction} pairs. Fetch writes into it through a valid/ready handshake, and decode drains it the same way. Decode stalls (hazards) and branch flushes act on the whole buffer.

## Interface
- PC_WIDTH, 32, width of the PC field
- INSTR_WIDTH, 32, width of the instruction field
- DEPTH, 4, number of entries; power of two, ≥ 2
- NOP_INSTR, all-zero, instruction value driven when the queue is empty
- clk  in  1  sole clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries (branch taken / redirect)
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  queue can accept an entry
- pc_in  in  PC_WIDTH  PC of the fetched instruction
- instr_in  in  INSTR_WIDTH  fetched instruction
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode consumes the head; low means hazard stall
- pc_out  out  PC_WIDTH  head PC
- instr_out  out  INSTR_WIDTH  head instruction
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry array plus write pointer, read pointer and occupancy counter, all registered.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
- Push: `in_valid && in_ready` writes {pc_in, instr_in} at the write pointer, then advances the write pointer.
- Pop: `out_valid && out_ready` advances the read pointer.
- Flow control:
  - in_ready = (count != DEPTH). It depends only on registered state, so there is no combinational path from out_ready.
  - out_valid = (count != 0).
- Outputs when the queue is empty:
  - instr_out = NOP_INSTR.
  - pc_out = 0.
  - Decode therefore sees a bubble, matching the old flush behaviour.
- Outputs when the queue is non-empty: pc_out and instr_out present the entry at the read pointer.
- Simultaneous push and pop: both take effect and count is unchanged. When full, no push can occur because in_ready is 0. When empty, no pop can occur because out_valid is 0.
- Flush:
  - On the next edge, both pointers and count go to 0.
  - A push or pop in the same cycle is discarded; flush has priority.
  - Array contents are not cleared.
- Hazard stall (out_ready = 0): the head holds, and fetch keeps filling until full.
- Reset (rst_n low, at any time including mid-operation):
  - Pointers and count go to 0 immediately.
  - in_ready = 1, out_valid = 0, pc_out = 0, instr_out = NOP_INSTR, count = 0.
  - The array itself needs no reset.

## Timing
- Latency: an entry pushed at edge N is visible on pc_out/instr_out with out_valid = 1 after edge N. There is one cycle of latency, the same as the old stage register.
- Throughput: one push and one pop per cycle sustained, at any occupancy from 1 to DEPTH-1.
- Full queue: one pop at edge N raises in_ready after edge N. The next push can land at edge N+1.
- Flush asserted before edge N: after edge N, out_valid = 0 and in_ready = 1. A fetch push in the cycle after the flush is accepted normally.
- All outputs are functions of registered state only.
- Reset deassertion takes effect at the first clk edge after rst_n goes high. Its synchronisation is the responsibility of the top level.

## Structure
- Shared package if_pkg holds:
  - the default NOP constant (NOP_INSTR_DEFAULT = 32'h0000_0000);
  - the default PC and instruction widths;
  - the packed entry typedef {pc, instr}, parametrised via package-level localparams for the defaults.
- Single module; no sub-module is warranted. The pointer/count logic is about 40 lines and stays inline.

## Test plan
- Reset and basic latency:
  - Stimulus: apply reset. Then push pc=0x100, instr=0x8C01_0004 with out_ready = 1.
  - Response: after reset, out_valid=0, instr_out=0, in_ready=1, count=0. One cycle after the push, out_valid=1, pc_out=0x100, and the entry pops on the following edge.
- Fill under stall:
  - Stimulus: out_ready = 0, push 5 entries (PC 0x0..0x4).
  - Response: the first four are accepted and count=4. in_ready=0 in the fifth cycle, so PC 0x4 is not accepted until a pop. The head holds PC 0x0 throughout.
- Drain with wrap-around:
  - Stimulus: continuous push and pop for 10 entries at DEPTH=4.
  - Response: outputs appear in order PC 0x0..0x9 and count stays at 1. The pointers wrap at least twice with no lost or duplicated entry.
- Push and pop while full:
  - Stimulus: the queue is full, out_ready = 1, in_valid = 1.
  - Response: the pop occurs, the push is refused that cycle because in_ready was 0, and the push is accepted the next cycle. Count goes 4 → 3 → 4 when out_ready is held low from the cycle after the pop, or 4 → 3 → 3 when out_ready stays high.
- Flush with simultaneous push:
  - Stimulus: 3 entries held, flush = 1 and in_valid = 1 in the same cycle.
  - Response: next cycle count=0, out_valid=0, instr_out=NOP_INSTR. The pushed entry never appears at the output.
- Reset mid-operation:
  - Stimulus: assert rst_n low between edges with 2 entries held.
  - Response: outputs go to reset values immediately, with no clock edge needed. After release, the first push appears after exactly one edge.

Source files
------------

// File: rtl/if_pkg.sv
// Shared IF/ID definitions: default field widths, the fetch bubble encoding
// and the packed {pc, instr} entry layout used between fetch and decode.
package if_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT    = 32;
    localparam int unsigned INSTR_WIDTH_DEFAULT = 32;

    localparam logic [INSTR_WIDTH_DEFAULT-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [PC_WIDTH_DEFAULT-1:0]    pc;
        logic [INSTR_WIDTH_DEFAULT-1:0] instr;
    } if_entry_t;

endpackage : if_pkg

// File: rtl/if_id_queue.sv
// DEPTH-entry FIFO of {PC, instruction} pairs decoupling fetch from decode.
// Flush empties the queue; an empty queue presents a bubble to decode.
module if_id_queue
    import if_pkg::*;
#(
    parameter int unsigned            PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter int unsigned            INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
    parameter int unsigned            DEPTH       = 4,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_WIDTH-1:0]        pc_in,
    input  logic [INSTR_WIDTH-1:0]     instr_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_WIDTH-1:0]        pc_out,
    output logic [INSTR_WIDTH-1:0]     instr_out,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0]    pc_mem_q    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s;
    logic             pop_s;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != {CNT_W{1'b0}});
    assign count     = count_q;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Next-state for pointers and occupancy; flush overrides any handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            pc_mem_q[wr_ptr_q]    <= pc_in;
            instr_mem_q[wr_ptr_q] <= instr_in;
        end
    end

    // Head presentation, with a bubble whenever the queue is empty.
    always_comb begin
        pc_out    = {PC_WIDTH{1'b0}};
        instr_out = NOP_INSTR;
        if (out_valid) begin
            pc_out    = pc_mem_q[rd_ptr_q];
            instr_out = instr_mem_q[rd_ptr_q];
        end else begin
            pc_out    = {PC_WIDTH{1'b0}};
            instr_out = NOP_INSTR;
        end
    end

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_if_id_queue;
    import if_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [2:0]  count;

    int n_checks;
    int n_errors;

    if_entry_t model_q[$];

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc_out    (pc_out),
        .instr_out (instr_out),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with what the model's contents imply.
    task automatic check_outputs(input string tag);
        int sz;
        sz = model_q.size();
        check_val({tag, ".count"},     64'(count),     64'(sz));
        check_val({tag, ".in_ready"},  64'(in_ready),  64'(sz != DEPTH));
        check_val({tag, ".out_valid"}, 64'(out_valid), 64'(sz != 0));
        check_val({tag, ".pc_out"},    64'(pc_out),    (sz != 0) ? 64'(model_q[0].pc)    : 64'd0);
        check_val({tag, ".instr_out"}, 64'(instr_out), (sz != 0) ? 64'(model_q[0].instr) : 64'(NOP_INSTR_DEFAULT));
    endtask

    // Drive one cycle from a falling edge, advance the model at the rising edge.
    task automatic step(input logic fl, input logic iv, input logic [31:0] pc,
                        input logic [31:0] ins, input logic ordy, input string tag);
        bit        m_push;
        bit        m_pop;
        if_entry_t e;
        flush     = fl;
        in_valid  = iv;
        pc_in     = pc;
        instr_in  = ins;
        out_ready = ordy;
        m_push    = iv && (model_q.size() != DEPTH);
        m_pop     = ordy && (model_q.size() != 0);
        e.pc      = pc;
        e.instr   = ins;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (m_pop)  void'(model_q.pop_front());
            if (m_push) model_q.push_back(e);
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pc_in     = 32'd0;
        instr_in  = 32'd0;

        #2;
        check_outputs("reset");
        check_val("reset.instr_zero", 64'(instr_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic latency: push then pop.
        step(1'b0, 1'b1, 32'h100, 32'h8C01_0004, 1'b1, "lat_push");
        check_val("lat.pc", 64'(pc_out), 64'h100);
        check_val("lat.valid", 64'(out_valid), 64'd1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "lat_pop");
        check_val("lat.empty", 64'(count), 64'd0);

        // Fill under stall; fifth entry refused.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 32'(i), 32'hA000_0000 + 32'(i), 1'b0, "fill");
            check_val("fill.head", 64'(pc_out), 64'h0);
        end
        check_val("fill.count", 64'(count), 64'd4);
        check_val("fill.in_ready", 64'(in_ready), 64'd0);

        // Full with push and pop: pop happens, push refused, then accepted.
        step(1'b0, 1'b1, 32'h4, 32'hA000_0004, 1'b1, "full_pp");
        check_val("full_pp.count", 64'(count), 64'd3);
        check_val("full_pp.head", 64'(pc_out), 64'h1);
        step(1'b0, 1'b1, 32'h4, 32'hA000_0004, 1'b0, "full_push");
        check_val("full_push.count", 64'(count), 64'd4);

        // Flush with simultaneous push.
        step(1'b1, 1'b1, 32'h77, 32'h7777_7777, 1'b0, "flush");
        check_val("flush.count", 64'(count), 64'd0);
        check_val("flush.instr", 64'(instr_out), 64'd0);

        // Drain with wrap-around: streaming push/pop keeps count at 1.
        step(1'b0, 1'b1, 32'h0, 32'hB000_0000, 1'b1, "stream0");
        for (int i = 1; i < 10; i++) begin
            check_val("stream.pc", 64'(pc_out), 64'(i - 1));
            step(1'b0, 1'b1, 32'(i), 32'hB000_0000 + 32'(i), 1'b1, "stream");
            check_val("stream.count", 64'(count), 64'd1);
        end
        check_val("stream.last", 64'(pc_out), 64'h9);

        // Reset mid-operation with two entries held.
        step(1'b0, 1'b1, 32'h20, 32'hC000_0020, 1'b0, "pre_rst");
        check_val("pre_rst.count", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        model_q.delete();
        #1;
        check_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 32'h300, 32'hD000_0300, 1'b0, "post_rst");
        check_val("post_rst.pc", 64'(pc_out), 64'h300);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 3) != 0),
                 $urandom, $urandom,
                 1'($urandom_range(0, 2) != 0),
                 "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_if_id_queue
